// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle sequencer and the shared datapath.
// master: sequencer (drives strobes, reads opcode/mem_ready); slave: datapath.
interface multicycle_control_if;
  logic [5:0] OpCode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_write_ncond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  OpCode, mem_ready,
    output pc_write, pc_write_cond, pc_write_ncond,
    output iord, mem_read, mem_write, ir_write,
    output reg_dst, mem_to_reg, reg_write,
    output alu_src_a, alu_src_b, alu_op, pc_source,
    output instr_done, illegal_op
  );

  modport slave (
    output OpCode, mem_ready,
    input  pc_write, pc_write_cond, pc_write_ncond,
    input  iord, mem_read, mem_write, ir_write,
    input  reg_dst, mem_to_reg, reg_write,
    input  alu_src_a, alu_src_b, alu_op, pc_source,
    input  instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// MIPS multicycle sequencer: steps the shared ALU/memory datapath through
// fetch/decode/execute/memory/writeback. Ports: clk, reset, bus (master).
module multicycle_control (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t     state_q, state_n;
  logic [5:0] op_q;
  logic       ill_q;
  logic       ill_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= 6'd0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      ill_q   <= ill_n;
      if (state_q == DECODE)
        op_q <= bus.OpCode;
    end
  end

  always_comb begin
    state_n            = FETCH;
    ill_n              = 1'b0;
    bus.pc_write       = 1'b0;
    bus.pc_write_cond  = 1'b0;
    bus.pc_write_ncond = 1'b0;
    bus.iord           = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.ir_write       = 1'b0;
    bus.reg_dst        = 1'b0;
    bus.mem_to_reg     = 1'b0;
    bus.reg_write      = 1'b0;
    bus.alu_src_a      = 1'b0;
    bus.alu_src_b      = 2'b00;
    bus.alu_op         = 2'b00;
    bus.pc_source      = 2'b00;
    bus.instr_done     = 1'b0;
    bus.illegal_op     = 1'b0;
    if (!reset) begin
      bus.illegal_op = ill_q;
      case (state_q)
        FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
          state_n = bus.mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          // live opcode is only trusted here; op_q holds it afterwards
          bus.alu_src_b = 2'b11;
          case (bus.OpCode)
            OP_LW, OP_SW:   state_n = MEMADR;
            OP_R:           state_n = EXEC;
            OP_BEQ, OP_BNE: state_n = BRANCH;
            OP_J:           state_n = JUMP;
            OP_ADDI:        state_n = ADDIEX;
            default: begin
              state_n = FETCH;
              ill_n   = 1'b1;
            end
          endcase
        end
        MEMADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          state_n = (op_q == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          bus.iord     = 1'b1;
          bus.mem_read = 1'b1;
          state_n = bus.mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          bus.mem_to_reg = 1'b1;
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
        end
        MEMWR: begin
          bus.iord       = 1'b1;
          bus.mem_write  = 1'b1;
          bus.instr_done = bus.mem_ready;
          state_n = bus.mem_ready ? FETCH : MEMWR;
        end
        EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b10;
          state_n = ALUWB;
        end
        ALUWB: begin
          bus.reg_dst    = 1'b1;
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
        end
        BRANCH: begin
          bus.alu_src_a      = 1'b1;
          bus.alu_op         = 2'b01;
          bus.pc_source      = 2'b01;
          bus.instr_done     = 1'b1;
          bus.pc_write_cond  = (op_q == OP_BEQ);
          bus.pc_write_ncond = (op_q == OP_BNE);
        end
        JUMP: begin
          bus.pc_source  = 2'b10;
          bus.pc_write   = 1'b1;
          bus.instr_done = 1'b1;
        end
        ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          state_n = ADDIWB;
        end
        ADDIWB: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
        end
        default: state_n = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle vectors,
// expected output words queued by stimulus, popped by a negedge monitor.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  localparam logic [18:0] PCW  = 19'(1) << 18;
  localparam logic [18:0] PCC  = 19'(1) << 17;
  localparam logic [18:0] PCN  = 19'(1) << 16;
  localparam logic [18:0] IORD = 19'(1) << 15;
  localparam logic [18:0] MRD  = 19'(1) << 14;
  localparam logic [18:0] MWR  = 19'(1) << 13;
  localparam logic [18:0] IRW  = 19'(1) << 12;
  localparam logic [18:0] RDST = 19'(1) << 11;
  localparam logic [18:0] M2R  = 19'(1) << 10;
  localparam logic [18:0] RW   = 19'(1) << 9;
  localparam logic [18:0] SA   = 19'(1) << 8;
  localparam logic [18:0] SB01 = 19'(1) << 6;
  localparam logic [18:0] SB10 = 19'(2) << 6;
  localparam logic [18:0] SB11 = 19'(3) << 6;
  localparam logic [18:0] AO01 = 19'(1) << 4;
  localparam logic [18:0] AO10 = 19'(2) << 4;
  localparam logic [18:0] PS01 = 19'(1) << 2;
  localparam logic [18:0] PS10 = 19'(2) << 2;
  localparam logic [18:0] DONE = 19'(1) << 1;
  localparam logic [18:0] ILL  = 19'(1);

  localparam logic [18:0] F1   = PCW | IRW | MRD | SB01;
  localparam logic [18:0] F0   = MRD | SB01;
  localparam logic [18:0] DEC  = SB11;
  localparam logic [18:0] NONE = 19'(0);

  localparam logic [5:0] JUNK = 6'b101010;

  typedef struct {
    logic [18:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  logic [18:0] got;
  assign got = {bus.pc_write, bus.pc_write_cond, bus.pc_write_ncond,
                bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.pc_source, bus.instr_done, bus.illegal_op};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s: got=%05h expected=%05h", e.nm, got, e.v);
      end
    end
  end

  task automatic step(input logic [5:0] op, input logic rdy,
                      input logic rst, input logic [18:0] v,
                      input string nm);
    exp_t e;
    bus.OpCode    = op;
    bus.mem_ready = rdy;
    reset         = rst;
    e.v  = v;
    e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.OpCode    = JUNK;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step(JUNK, 1, 1, NONE, "init_rst0");
    step(JUNK, 1, 1, NONE, "init_rst1");

    step(JUNK, 1, 0, F1,        "r0_fetch");
    step(6'b000000, 1, 0, DEC,  "r0_decode");
    step(JUNK, 1, 0, SA | AO10, "r0_exec");
    step(JUNK, 1, 1, NONE,      "rst_exec0");
    step(JUNK, 1, 1, NONE,      "rst_exec1");
    step(JUNK, 1, 1, NONE,      "rst_exec2");
    step(JUNK, 0, 0, F0,        "post_rst_fetch");

    step(JUNK, 1, 0, F1,        "r_fetch");
    step(6'b000000, 1, 0, DEC,  "r_decode");
    step(JUNK, 1, 0, SA | AO10, "r_exec");
    step(JUNK, 1, 0, RDST | RW | DONE, "r_aluwb");

    step(JUNK, 1, 0, F1,        "lw_fetch");
    step(6'b100011, 1, 0, DEC,  "lw_decode");
    step(JUNK, 1, 0, SA | SB10, "lw_memadr");
    step(JUNK, 0, 0, IORD | MRD, "lw_memrd_w0");
    step(JUNK, 0, 0, IORD | MRD, "lw_memrd_w1");
    step(JUNK, 1, 0, IORD | MRD, "lw_memrd");
    step(JUNK, 1, 0, M2R | RW | DONE, "lw_memwb");

    step(JUNK, 1, 0, F1,        "sw_fetch");
    step(6'b101011, 1, 0, DEC,  "sw_decode");
    step(JUNK, 1, 0, SA | SB10, "sw_memadr");
    step(JUNK, 1, 0, IORD | MWR | DONE, "sw_memwr");

    step(JUNK, 1, 0, F1,        "j_fetch");
    step(6'b000010, 1, 0, DEC,  "j_decode");
    step(JUNK, 1, 0, PS10 | PCW | DONE, "j_jump");

    step(JUNK, 1, 0, F1,        "beq_fetch");
    step(6'b000100, 1, 0, DEC,  "beq_decode");
    step(6'b000101, 1, 0, SA | AO01 | PS01 | PCC | DONE, "beq_branch");

    step(JUNK, 1, 0, F1,        "bne_fetch");
    step(6'b000101, 1, 0, DEC,  "bne_decode");
    step(6'b000100, 1, 0, SA | AO01 | PS01 | PCN | DONE, "bne_branch");

    step(JUNK, 1, 0, F1,        "addi_fetch");
    step(6'b001000, 1, 0, DEC,  "addi_decode");
    step(JUNK, 1, 0, SA | SB10, "addi_ex");
    step(JUNK, 1, 0, RW | DONE, "addi_wb");

    step(JUNK, 1, 0, F1,        "ill_fetch");
    step(6'b111111, 1, 0, DEC,  "ill_decode");
    step(JUNK, 0, 0, F0 | ILL,  "ill_pulse");
    step(JUNK, 0, 0, F0,        "ill_clear");
    step(JUNK, 1, 0, F1,        "ill_fetch2");
    step(6'b000010, 1, 0, DEC,  "ill_j_decode");
    step(JUNK, 1, 0, PS10 | PCW | DONE, "ill_j_jump");
    step(JUNK, 0, 0, F0,        "final_fetch");

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
